// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU-op and alu_control codes, datapath mux selects and fault causes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StFault
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut  = 2'b00;
    localparam logic [1:0] ResMemData = 2'b01;
    localparam logic [1:0] ResAlu     = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    localparam logic [1:0] FaultNone    = 2'b00;
    localparam logic [1:0] FaultIllegal = 2'b01;
    localparam logic [1:0] FaultTimeout = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath/memory signal bundle; master is the control unit side.
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned INSTRET_W = 32
) ();

    logic                 run;
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic                 zero;
    logic                 mem_ready;

    logic                 mem_req;
    logic                 mem_write;
    logic                 adr_src;
    logic                 ir_write;
    logic                 pc_write;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic [1:0]           imm_src;
    logic [2:0]           alu_control;
    logic [INSTRET_W-1:0] instret;
    logic                 fault;
    logic [1:0]           fault_code;

    modport master (
        input  run, op, funct3, funct7_5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               instret, fault, fault_code
    );

    modport slave (
        output run, op, funct3, funct7_5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               instret, fault, fault_code
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-op/funct decoder; unsupported funct3 values fall back to ADD.
module alu_ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        case (alu_op_i)
            AluOpSub: alu_control_o = AluSub;
            AluOpFunct: begin
                case (funct3_i)
                    // SUB only for R-type; addi with instr[30] set is still ADD
                    3'b000: if (funct7_5_i && op5_i) alu_control_o = AluSub;
                    3'b010: alu_control_o = AluSlt;
                    3'b110: alu_control_o = AluOr;
                    3'b111: alu_control_o = AluAnd;
                    default: alu_control_o = AluAdd;
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences the shared datapath, handshakes with one memory
// port, counts retired instructions and latches a sticky fault.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned INSTRET_W      = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus
);

    state_e               state_q, state_d;
    logic [31:0]          wait_q, wait_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic [1:0]           fault_code_q, fault_code_d;

    logic       mem_req, mem_write, ir_write, pc_write, reg_write, adr_src;
    logic       retire, wait_limit;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;

    // True on the wait cycle that would bring the counter up to the limit
    assign wait_limit = (TIMEOUT_CYCLES != 0) && (wait_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        retire       = 1'b0;
        alu_op       = AluOpAdd;
        alu_src_a    = SrcAPc;
        alu_src_b    = SrcBRs2;
        result_src   = ResAluOut;
        unique case (state_q)
            StFetch: begin
                mem_req    = bus.run;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
                if (bus.run && bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (bus.run && wait_limit) begin
                    state_d      = StFault;
                    fault_code_d = FaultTimeout;
                end
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpImm:           state_d = StExecI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default: begin
                        state_d      = StFault;
                        fault_code_d = FaultIllegal;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                state_d   = bus.op[5] ? StMemWrite : StMemRead;
            end
            StMemRead, StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = (state_q == StMemWrite);
                adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = (state_q == StMemWrite) ? StFetch : StMemWb;
                    retire  = (state_q == StMemWrite);
                end else if (wait_limit) begin
                    state_d      = StFault;
                    fault_code_d = FaultTimeout;
                end
            end
            StMemWb: begin
                result_src = ResMemData;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StExecR, StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = (state_q == StExecI) ? SrcBImm : SrcBRs2;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBeq: begin
                alu_src_a = SrcARs1;
                alu_op    = AluOpSub;
                pc_write  = bus.zero;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StJal: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
            default: state_d = StFault;
        endcase

        if (mem_req && !bus.mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + 32'd1;
        end else begin
            wait_d = '0;
        end
        instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            wait_q       <= '0;
            instret_q    <= '0;
            fault_code_q <= FaultNone;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            instret_q    <= instret_d;
            fault_code_q <= fault_code_d;
        end
    end

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op_i      (alu_op),
        .funct3_i      (bus.funct3),
        .funct7_5_i    (bus.funct7_5),
        .op5_i         (bus.op[5]),
        .alu_control_o (bus.alu_control)
    );

    always_comb begin
        case (bus.op)
            OpStore: bus.imm_src = ImmS;
            OpBeq:   bus.imm_src = ImmB;
            OpJal:   bus.imm_src = ImmJ;
            default: bus.imm_src = ImmI;
        endcase
    end

    // Enables are gated by reset so they drop the moment rst_n falls
    assign bus.mem_req    = mem_req & rst_n;
    assign bus.mem_write  = mem_write & rst_n;
    assign bus.ir_write   = ir_write & rst_n;
    assign bus.pc_write   = pc_write & rst_n;
    assign bus.reg_write  = reg_write & rst_n;
    assign bus.adr_src    = adr_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.result_src = result_src;
    assign bus.instret    = instret_q;
    assign bus.fault      = (state_q == StFault);
    assign bus.fault_code = fault_code_q;

endmodule
